// File: rtl/cpu_trace_buffer_if.sv
// Control, observation and read-port signals of the CPU execution-trace buffer.
// The CPU side / test driver uses master, the trace buffer uses slave.
interface cpu_trace_buffer_if #(
    parameter int PC_W   = 32,
    parameter int OP_W   = 6,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic              arm;
    logic              trig_mode;
    logic [OP_W-1:0]   trig_op;
    logic              sample_valid;
    logic [PC_W-1:0]   pc;
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] data;
    logic              rd_en;

    logic              rd_valid;
    logic [PC_W-1:0]   rd_pc;
    logic [OP_W-1:0]   rd_op;
    logic [DATA_W-1:0] rd_data;
    logic [CW-1:0]     count;
    logic [1:0]        state;
    logic              triggered;
    logic              done;

    modport master (
        output arm, trig_mode, trig_op, sample_valid, pc, op, data, rd_en,
        input  rd_valid, rd_pc, rd_op, rd_data, count, state, triggered, done
    );

    modport slave (
        input  arm, trig_mode, trig_op, sample_valid, pc, op, data, rd_en,
        output rd_valid, rd_pc, rd_op, rd_data, count, state, triggered, done
    );
endinterface

// File: rtl/cpu_trace_buffer.sv
// Execution-trace ring buffer: arm, trigger (immediate or opcode match), keep POST
// samples after the trigger, then drain oldest-first through a registered read port.
module cpu_trace_buffer #(
    parameter int PC_W   = 32,
    parameter int OP_W   = 6,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int POST   = 4
) (
    input logic              clk,
    input logic              rst,
    cpu_trace_buffer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = PC_W + OP_W + DATA_W;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_e;

    state_e            state_q;
    logic [AW-1:0]     wp_q, wp_d;
    logic [CW-1:0]     count_q, count_d;
    logic [AW-1:0]     post_q;
    logic              triggered_q;
    logic              done_q;
    logic              rd_valid_q;
    logic [PC_W-1:0]   rd_pc_q;
    logic [OP_W-1:0]   rd_op_q;
    logic [DATA_W-1:0] rd_data_q;
    logic [EW-1:0]     mem_q [DEPTH];

    logic              writeEn;
    logic              trigHit;
    logic              readEn;
    logic [AW-1:0]     rdIdx;

    // A concurrent arm always wins: it discards the sample and drops any read.
    always_comb begin
        writeEn = ((state_q == ARMED) || (state_q == CAPTURE)) && bus.sample_valid && !bus.arm;
        trigHit = (state_q == ARMED) && writeEn && (!bus.trig_mode || (bus.op == bus.trig_op));
        readEn  = (state_q == DONE) && bus.rd_en && !bus.arm && (count_q != '0);
        rdIdx   = wp_q - count_q[AW-1:0];
        wp_d    = wp_q;
        count_d = count_q;
        if (writeEn) begin
            wp_d = wp_q + AW'(1);
            if (count_q != CW'(DEPTH)) begin
                count_d = count_q + CW'(1);
            end
        end else if (readEn) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (writeEn) begin
            mem_q[wp_q] <= {bus.pc, bus.op, bus.data};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            wp_q        <= '0;
            count_q     <= '0;
            post_q      <= '0;
            triggered_q <= 1'b0;
            done_q      <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_pc_q     <= '0;
            rd_op_q     <= '0;
            rd_data_q   <= '0;
        end else begin
            rd_valid_q <= 1'b0;
            if (bus.arm) begin
                state_q     <= ARMED;
                wp_q        <= '0;
                count_q     <= '0;
                post_q      <= '0;
                triggered_q <= 1'b0;
                done_q      <= 1'b0;
            end else begin
                wp_q    <= wp_d;
                count_q <= count_d;
                case (state_q)
                    ARMED: begin
                        if (trigHit) begin
                            triggered_q <= 1'b1;
                            if (POST == 0) begin
                                state_q <= DONE;
                                done_q  <= 1'b1;
                            end else begin
                                post_q  <= AW'(POST);
                                state_q <= CAPTURE;
                            end
                        end
                    end
                    CAPTURE: begin
                        // Gap cycles (no valid sample) leave the post counter alone.
                        if (writeEn) begin
                            post_q <= post_q - AW'(1);
                            if (post_q == AW'(1)) begin
                                state_q <= DONE;
                                done_q  <= 1'b1;
                            end
                        end
                    end
                    DONE: begin
                        if (readEn) begin
                            rd_valid_q                       <= 1'b1;
                            {rd_pc_q, rd_op_q, rd_data_q}    <= mem_q[rdIdx];
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.state     = state_q;
    assign bus.count     = count_q;
    assign bus.triggered = triggered_q;
    assign bus.done      = done_q;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.rd_pc     = rd_pc_q;
    assign bus.rd_op     = rd_op_q;
    assign bus.rd_data   = rd_data_q;
endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Scoreboard bench for cpu_trace_buffer: a queue-based capture model predicts every
// cycle, and popped entries are queued as expected read results.
module tb_cpu_trace_buffer;
    localparam int PC_W   = 32;
    localparam int OP_W   = 6;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 8;
    localparam int POST   = 3;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] data;
    } entry_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    cpu_trace_buffer_if #(.PC_W(PC_W), .OP_W(OP_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

    cpu_trace_buffer #(
        .PC_W(PC_W), .OP_W(OP_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .POST(POST)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int       checkCount = 0;
    int       passCount  = 0;
    int       mState     = 0;
    int       mPost      = 0;
    entry_t   mBuf[$];
    entry_t   expQ[$];
    logic     expRead    = 1'b0;
    entry_t   holdEntry  = '0;
    logic     curMode    = 1'b0;
    logic [OP_W-1:0] curOp = '0;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed === expected) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    endtask

    // Compare every visible output against the model; read data is drained from expQ.
    task automatic checkCycle();
        entry_t e;
        checkOutput("state", 64'(bus.state), 64'(mState));
        checkOutput("count", 64'(bus.count), 64'(mBuf.size()));
        checkOutput("triggered", 64'(bus.triggered), 64'(mState >= 2));
        checkOutput("done", 64'(bus.done), 64'(mState == 3));
        checkOutput("rdValid", 64'(bus.rd_valid), 64'(expRead));
        if (bus.rd_valid) begin
            if (expQ.size() == 0) begin
                checkOutput("scoreboardEmpty", 64'(bus.rd_valid), 64'(0));
            end else begin
                e = expQ.pop_front();
                holdEntry = e;
            end
        end
        checkOutput("rdPc", 64'(bus.rd_pc), 64'(holdEntry.pc));
        checkOutput("rdOp", 64'(bus.rd_op), 64'(holdEntry.op));
        checkOutput("rdData", 64'(bus.rd_data), 64'(holdEntry.data));
    endtask

    task automatic applyStimulus(input logic a, input logic sv, input logic [PC_W-1:0] p,
                                 input logic [OP_W-1:0] o, input logic [DATA_W-1:0] d,
                                 input logic re);
        entry_t e;
        bus.arm          = a;
        bus.trig_mode    = curMode;
        bus.trig_op      = curOp;
        bus.sample_valid = sv;
        bus.pc           = p;
        bus.op           = o;
        bus.data         = d;
        bus.rd_en        = re;
        e = '{pc: p, op: o, data: d};
        expRead = 1'b0;
        if (a) begin
            mState = 1;
            mBuf.delete();
        end else begin
            case (mState)
                1: if (sv) begin
                    mBuf.push_back(e);
                    if (mBuf.size() > DEPTH) void'(mBuf.pop_front());
                    if (!curMode || o == curOp) begin
                        if (POST == 0) mState = 3;
                        else begin
                            mPost  = POST;
                            mState = 2;
                        end
                    end
                end
                2: if (sv) begin
                    mBuf.push_back(e);
                    if (mBuf.size() > DEPTH) void'(mBuf.pop_front());
                    mPost--;
                    if (mPost == 0) mState = 3;
                end
                3: if (re && mBuf.size() > 0) begin
                    expQ.push_back(mBuf.pop_front());
                    expRead = 1'b1;
                end
                default: ;
            endcase
        end
        @(posedge clk);
        #1;
        checkCycle();
    endtask

    task automatic idleCycles(input int n, input logic re);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, '0, '0, '0, re);
    endtask

    task automatic doReset();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            bus.arm          = $urandom_range(0, 1) != 0;
            bus.trig_mode    = $urandom_range(0, 1) != 0;
            bus.trig_op      = OP_W'($urandom_range(0, 63));
            bus.sample_valid = $urandom_range(0, 1) != 0;
            bus.pc           = $urandom;
            bus.op           = OP_W'($urandom_range(0, 63));
            bus.data         = $urandom;
            bus.rd_en        = $urandom_range(0, 1) != 0;
            @(posedge clk);
            #1;
        end
        mState = 0;
        mPost  = 0;
        mBuf.delete();
        expQ.delete();
        expRead   = 1'b0;
        holdEntry = '0;
        checkCycle();
        rst = 1'b0;
    endtask

    initial begin
        $display("[TB] cpu_trace_buffer bench, DEPTH=%0d POST=%0d", DEPTH, POST);
        doReset();

        // Immediate trigger: done after the 4th sample, later samples ignored.
        curMode = 1'b0;
        applyStimulus(1'b1, 1'b0, '0, '0, '0, 1'b0);
        for (int i = 0; i < 6; i++)
            applyStimulus(1'b0, 1'b1, PC_W'(4 * i), OP_W'(i), $urandom, 1'b0);
        checkOutput("immCount", 64'(bus.count), 64'(4));
        idleCycles(5, 1'b1);

        // Opcode trigger with wrap-around: oldest kept entry is pc 0x14.
        curMode = 1'b1;
        curOp   = 6'h23;
        applyStimulus(1'b1, 1'b0, '0, '0, '0, 1'b0);
        idleCycles(1, 1'b1);
        for (int i = 0; i < 13; i++)
            applyStimulus(1'b0, 1'b1, PC_W'(4 * i), (i == 9) ? 6'h23 : 6'h00, $urandom, 1'b0);
        checkOutput("wrapCount", 64'(bus.count), 64'(8));
        applyStimulus(1'b0, 1'b0, '0, '0, '0, 1'b1);
        checkOutput("wrapFirstPc", 64'(bus.rd_pc), 64'(32'h14));
        idleCycles(8, 1'b1);

        // Same capture with a 3-cycle gap after the trigger, then arm+rd_en mid-drain.
        applyStimulus(1'b1, 1'b0, '0, '0, '0, 1'b0);
        for (int i = 0; i < 13; i++) begin
            applyStimulus(1'b0, 1'b1, PC_W'(4 * i), (i == 9) ? 6'h23 : 6'h00, $urandom, 1'b0);
            if (i == 9) begin
                for (int g = 0; g < 3; g++)
                    applyStimulus(1'b0, 1'b0, $urandom, 6'h23, $urandom, 1'b0);
            end
        end
        idleCycles(3, 1'b1);
        applyStimulus(1'b1, 1'b0, '0, '0, '0, 1'b1);
        checkOutput("armWinsCount", 64'(bus.count), 64'(0));

        // Re-arm while in CAPTURE with six entries; the concurrent sample is dropped.
        for (int i = 0; i < 6; i++)
            applyStimulus(1'b0, 1'b1, PC_W'(32'h100 + 4 * i), (i == 5) ? 6'h23 : 6'h01, $urandom, 1'b0);
        checkOutput("reArmPreCount", 64'(bus.count), 64'(6));
        applyStimulus(1'b1, 1'b1, 32'hDEAD_BEEF, 6'h23, $urandom, 1'b0);
        curMode = 1'b0;
        for (int i = 0; i < 4; i++)
            applyStimulus(1'b0, 1'b1, PC_W'(32'h200 + 4 * i), OP_W'(i), $urandom, 1'b0);
        idleCycles(5, 1'b1);

        // Reset in the middle of a capture, then a read that must be ignored.
        applyStimulus(1'b1, 1'b0, '0, '0, '0, 1'b0);
        for (int i = 0; i < 2; i++)
            applyStimulus(1'b0, 1'b1, PC_W'(32'h300 + 4 * i), '0, $urandom, 1'b0);
        doReset();
        idleCycles(2, 1'b1);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
